mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the ReadMem stage. Consumes its instruction bundle plus operand values.
- Executes RV32 loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) against a data memory over a req/gnt + rvalid interface.
- Passes all other instructions through with one-cycle latency.
- Applies valid/ready back-pressure both upstream and downstream.

Parameters:
- ADDR_WIDTH, 32: byte-address width. Address ports carry word addresses of ADDR_WIDTH-2 bits, dropping the 2 LSBs.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  stage can accept a bundle
- in_pc  in  ADDR_WIDTH-2  instruction word address
- in_insn  in  32  instruction word
- in_rs1  in  32  rs1 operand value
- in_rs2  in  32  rs2 operand value (store data)
- dmem_req  out  1  data memory request
- dmem_gnt  in  1  request accepted this cycle
- dmem_we  out  1  1 = store, 0 = load
- dmem_be  out  4  byte enables
- dmem_addr  out  ADDR_WIDTH-2  word address
- dmem_wdata  out  32  store data, lane-replicated
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- out_valid  out  1  output bundle valid
- out_ready  in  1  downstream accepts the bundle
- out_pc  out  ADDR_WIDTH-2  pc of the bundle
- out_insn  out  32  insn of the bundle
- out_rd_data  out  32  load result, else 0
- out_rd_we  out  1  write rd: load with rd != 0 and no fault
- out_misalign  out  1  misaligned access fault

Behaviour:
- Reset (rst == 0 at posedge):
  - state = IDLE.
  - dmem_req, out_valid, out_rd_we, out_misalign = 0.
  - out_pc, out_insn, out_rd_data, dmem_addr, dmem_be, dmem_wdata = 0.
  - dmem_we = 0.
- Reset mid-transaction: the transaction is abandoned. An rvalid arriving later in IDLE is ignored.
- States: IDLE, REQ, WAIT.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Transfer occurs when in_valid && in_ready.
- Effective address EA = in_rs1 + sext(imm), modulo 2^32.
  - Loads (opcode 0000011) use the I-type immediate.
  - Stores (opcode 0100011) use the S-type immediate.
  - EA is truncated to ADDR_WIDTH bits.
- Misaligned: halfword with EA[0] != 0, or word with EA[1:0] != 0.
  - No dmem request is issued.
  - out_valid next cycle, out_misalign = 1, out_rd_we = 0, out_rd_data = 0.
- Non-memory opcode, or undefined funct3 under a load/store opcode:
  - out_valid next cycle, out_rd_we = 0, out_rd_data = 0, out_misalign = 0.
- Aligned load/store accepted at cycle T:
  - Go to REQ. dmem_req = 1 from T+1.
  - dmem_addr = EA[ADDR_WIDTH-1:2], held stable with dmem_we, dmem_be and dmem_wdata until dmem_gnt.
- Byte enables and write data:
  - SB: be = 1 << EA[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 if EA[1] == 0, else 1100; wdata = {2{rs2[15:0]}}.
  - SW: be = 1111; wdata = rs2.
  - Loads drive the same be pattern as the corresponding store width.
- On dmem_gnt in REQ: dmem_req deasserts the next cycle.
  - Store: return to IDLE; out_valid next cycle, out_rd_we = 0.
  - Load: go to WAIT.
- WAIT: on dmem_rvalid, extract the byte/half at EA[1:0] and sign-extend (LB/LH) or zero-extend (LBU/LHU); LW uses the full word.
  - Register the result in out_rd_data; out_valid next cycle.
  - out_rd_we = (rd != 0); return to IDLE.
- rvalid in the same cycle as gnt is not legal. The memory returns rvalid no earlier than the cycle after gnt.
- Minimum latencies, accept at T:
  - Pass-through/fault: out_valid at T+1.
  - Store with immediate gnt: out_valid at T+2.
  - Load with gnt at T+1 and rvalid at T+2: out_valid at T+3.
- Output hold: while out_valid && !out_ready, all out_* hold stable. out_valid clears on out_ready unless a new bundle loads in the same cycle.
- Back-to-back: pass-through bundles sustain 1 per cycle when out_ready = 1. A memory op blocks in_ready until it completes.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with in_valid = 1 -> out_valid = 0, dmem_req = 0, in_ready = 0 during reset; in_ready = 1 the cycle after release.
- LB: rs1 = 0x1000, imm = 3; gnt immediate; rdata = 0x80FF_0000 -> dmem_addr = 0x400, be = 1000, out_rd_data = 0xFFFF_FF80, out_rd_we = 1, out_valid at T+3.
- SH: rs1 = 0x2002, imm = 0, rs2 = 0x1234_ABCD; gnt delayed 2 cycles -> dmem_req held 3 cycles with stable addr = 0x800, be = 1100, wdata = 0xABCD_ABCD, we = 1; out_valid one cycle after gnt, out_rd_we = 0.
- LW: rs1 = 0x1002 -> no dmem_req; out_valid at T+1 with out_misalign = 1, out_rd_we = 0.
- Back-pressure: three ADDI bundles back-to-back with out_ready = 0 for 2 cycles -> first bundle held stable; in_ready = 0; no bundle lost or duplicated; order preserved.
- Reset while in WAIT, then rvalid arrives -> ignored; out_valid stays 0; next load completes normally with LBU rdata = 0x0000_00F0 at EA[1:0] = 0 -> out_rd_data = 0x0000_00F0.

Source files
------------

// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Memory-access pipeline stage that sits after ReadMem. Executes
//            RV32 loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) against a
//            req/gnt + rvalid data memory. All other instructions pass
//            through with one cycle of latency. Uses valid/ready handshakes
//            on both the upstream and downstream sides.
// Ports    : clk, rst (synchronous, active-low)
//            in_*_i    upstream bundle (valid/ready, pc, insn, rs1, rs2)
//            dmem_*    data memory request / response
//            out_*     downstream bundle (valid/ready, pc, insn, rd data,
//                      rd write enable, misalign fault)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // upstream
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ADDR_WIDTH-3:0] in_pc_i,
  input  logic [31:0]           in_insn_i,
  input  logic [31:0]           in_rs1_i,
  input  logic [31:0]           in_rs2_i,
  // data memory
  output logic                  dmem_req_o,
  input  logic                  dmem_gnt_i,
  output logic                  dmem_we_o,
  output logic [3:0]            dmem_be_o,
  output logic [ADDR_WIDTH-3:0] dmem_addr_o,
  output logic [31:0]           dmem_wdata_o,
  input  logic                  dmem_rvalid_i,
  input  logic [31:0]           dmem_rdata_i,
  // downstream
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH-3:0] out_pc_o,
  output logic [31:0]           out_insn_o,
  output logic [31:0]           out_rd_data_o,
  output logic                  out_rd_we_o,
  output logic                  out_misalign_o
);

  localparam logic [6:0] C_OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-3:0]   out_pc_q, out_pc_d;
  logic [31:0]             out_insn_q, out_insn_d;
  logic [31:0]             out_rd_data_q, out_rd_data_d;
  logic                    out_rd_we_q, out_rd_we_d;
  logic                    out_misalign_q, out_misalign_d;
  logic [ADDR_WIDTH-3:0]   req_addr_q, req_addr_d;
  logic [3:0]              req_be_q, req_be_d;
  logic [31:0]             req_wdata_q, req_wdata_d;
  logic                    req_we_q, req_we_d;
  // Bundle of the memory op in flight, released to the output on completion
  logic [ADDR_WIDTH-3:0]   op_pc_q, op_pc_d;
  logic [31:0]             op_insn_q, op_insn_d;
  logic [1:0]              op_off_q, op_off_d;

  // --------------------------------------------------------------------------
  // Decode and effective address of the incoming bundle
  // --------------------------------------------------------------------------
  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [1:0]            w_size;
  logic [31:0]           w_imm_i;
  logic [31:0]           w_imm_s;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_is_mem;
  logic [31:0]           w_ea_full;
  logic [ADDR_WIDTH-1:0] w_ea;
  logic                  w_misalign;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic                  w_fire;
  logic                  w_unused_bits;

  assign w_opcode  = in_insn_i[6:0];
  assign w_funct3  = in_insn_i[14:12];
  assign w_size    = w_funct3[1:0];
  assign w_imm_i   = {{20{in_insn_i[31]}}, in_insn_i[31:20]};
  assign w_imm_s   = {{20{in_insn_i[31]}}, in_insn_i[31:25], in_insn_i[11:7]};

  // Undefined funct3 values under a load/store opcode fall through as plain
  // pass-through bundles.
  assign w_is_load  = (w_opcode == C_OPC_LOAD) &&
                      ((w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                       (w_funct3 == 3'b010) || (w_funct3 == 3'b100) ||
                       (w_funct3 == 3'b101));
  assign w_is_store = (w_opcode == C_OPC_STORE) &&
                      ((w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                       (w_funct3 == 3'b010));
  assign w_is_mem   = w_is_load || w_is_store;

  assign w_ea_full  = in_rs1_i + (w_is_store ? w_imm_s : w_imm_i);
  assign w_ea       = w_ea_full[ADDR_WIDTH-1:0];

  assign w_misalign = w_is_mem &&
                      (((w_size == 2'b01) && w_ea[0]) ||
                       ((w_size == 2'b10) && (w_ea[1:0] != 2'b00)));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = in_rs2_i;
    case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << w_ea[1:0];
        w_wdata = {4{in_rs2_i[7:0]}};
      end
      2'b01: begin
        w_be    = w_ea[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{in_rs2_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = in_rs2_i;
      end
    endcase
  end

  // rs1 register field and any EA bits above ADDR_WIDTH are not needed here
  assign w_unused_bits = ^{in_insn_i[19:15], w_ea_full};

  // Reset also closes the input so nothing is taken while it is asserted
  assign in_ready_o = rst && (state_q == S_IDLE) && (!out_valid_q || out_ready_i);
  assign w_fire     = in_valid_i && in_ready_o;

  // --------------------------------------------------------------------------
  // Load data extraction for the op in flight
  // --------------------------------------------------------------------------
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;

  always_comb begin
    w_ld_byte = dmem_rdata_i[7:0];
    case (op_off_q)
      2'd1:    w_ld_byte = dmem_rdata_i[15:8];
      2'd2:    w_ld_byte = dmem_rdata_i[23:16];
      2'd3:    w_ld_byte = dmem_rdata_i[31:24];
      default: w_ld_byte = dmem_rdata_i[7:0];
    endcase
    w_ld_half = op_off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (op_insn_q[14:12])
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_data = {24'd0, w_ld_byte};
      3'b101:  w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = dmem_rdata_i;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state and output-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    // A presented bundle is retired by out_ready unless replaced below
    out_valid_d    = out_valid_q && !out_ready_i;
    out_pc_d       = out_pc_q;
    out_insn_d     = out_insn_q;
    out_rd_data_d  = out_rd_data_q;
    out_rd_we_d    = out_rd_we_q;
    out_misalign_d = out_misalign_q;
    req_addr_d     = req_addr_q;
    req_be_d       = req_be_q;
    req_wdata_d    = req_wdata_q;
    req_we_d       = req_we_q;
    op_pc_d        = op_pc_q;
    op_insn_d      = op_insn_q;
    op_off_d       = op_off_q;

    case (state_q)
      S_IDLE: begin
        if (w_fire) begin
          if (w_is_mem && !w_misalign) begin
            state_d     = S_REQ;
            req_addr_d  = w_ea[ADDR_WIDTH-1:2];
            req_be_d    = w_be;
            req_wdata_d = w_wdata;
            req_we_d    = w_is_store;
            op_pc_d     = in_pc_i;
            op_insn_d   = in_insn_i;
            op_off_d    = w_ea[1:0];
          end else begin
            out_valid_d    = 1'b1;
            out_pc_d       = in_pc_i;
            out_insn_d     = in_insn_i;
            out_rd_data_d  = 32'd0;
            out_rd_we_d    = 1'b0;
            out_misalign_d = w_misalign;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          if (req_we_q) begin
            state_d        = S_IDLE;
            out_valid_d    = 1'b1;
            out_pc_d       = op_pc_q;
            out_insn_d     = op_insn_q;
            out_rd_data_d  = 32'd0;
            out_rd_we_d    = 1'b0;
            out_misalign_d = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d        = S_IDLE;
          out_valid_d    = 1'b1;
          out_pc_d       = op_pc_q;
          out_insn_d     = op_insn_q;
          out_rd_data_d  = w_ld_data;
          out_rd_we_d    = (op_insn_q[11:7] != 5'd0);
          out_misalign_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_insn_q     <= 32'd0;
      out_rd_data_q  <= 32'd0;
      out_rd_we_q    <= 1'b0;
      out_misalign_q <= 1'b0;
      req_addr_q     <= '0;
      req_be_q       <= 4'd0;
      req_wdata_q    <= 32'd0;
      req_we_q       <= 1'b0;
      op_pc_q        <= '0;
      op_insn_q      <= 32'd0;
      op_off_q       <= 2'd0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_insn_q     <= out_insn_d;
      out_rd_data_q  <= out_rd_data_d;
      out_rd_we_q    <= out_rd_we_d;
      out_misalign_q <= out_misalign_d;
      req_addr_q     <= req_addr_d;
      req_be_q       <= req_be_d;
      req_wdata_q    <= req_wdata_d;
      req_we_q       <= req_we_d;
      op_pc_q        <= op_pc_d;
      op_insn_q      <= op_insn_d;
      op_off_q       <= op_off_d;
    end
  end

  assign dmem_req_o     = (state_q == S_REQ);
  assign dmem_we_o      = req_we_q;
  assign dmem_be_o      = req_be_q;
  assign dmem_addr_o    = req_addr_q;
  assign dmem_wdata_o   = req_wdata_q;

  assign out_valid_o    = out_valid_q;
  assign out_pc_o       = out_pc_q;
  assign out_insn_o     = out_insn_q;
  assign out_rd_data_o  = out_rd_data_q;
  assign out_rd_we_o    = out_rd_we_q;
  assign out_misalign_o = out_misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage. Expected output
//            bundles are queued when stimulus is driven and compared when the
//            stage presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int AW = 32;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [AW-3:0] in_pc;
  logic [31:0]   in_insn, in_rs1, in_rs2;
  logic          dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
  logic [3:0]    dmem_be;
  logic [AW-3:0] dmem_addr;
  logic [31:0]   dmem_wdata, dmem_rdata;
  logic          out_valid, out_ready, out_rd_we, out_misalign;
  logic [AW-3:0] out_pc;
  logic [31:0]   out_insn, out_rd_data;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_pc_i        (in_pc),
    .in_insn_i      (in_insn),
    .in_rs1_i       (in_rs1),
    .in_rs2_i       (in_rs2),
    .dmem_req_o     (dmem_req),
    .dmem_gnt_i     (dmem_gnt),
    .dmem_we_o      (dmem_we),
    .dmem_be_o      (dmem_be),
    .dmem_addr_o    (dmem_addr),
    .dmem_wdata_o   (dmem_wdata),
    .dmem_rvalid_i  (dmem_rvalid),
    .dmem_rdata_i   (dmem_rdata),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_pc_o       (out_pc),
    .out_insn_o     (out_insn),
    .out_rd_data_o  (out_rd_data),
    .out_rd_we_o    (out_rd_we),
    .out_misalign_o (out_misalign)
  );

  typedef struct packed {
    logic [AW-3:0] pc;
    logic [31:0]   insn;
    logic [31:0]   rd_data;
    logic          rd_we;
    logic          mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, 5'd1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [2:0] f3);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic exp_t observed();
    exp_t a;
    a.pc = out_pc; a.insn = out_insn; a.rd_data = out_rd_data;
    a.rd_we = out_rd_we; a.mis = out_misalign;
    return a;
  endfunction

  function automatic exp_t mk_exp(input logic [AW-3:0] pc, input logic [31:0] insn,
                                  input logic [31:0] rd, input logic we, input logic mis);
    exp_t e;
    e.pc = pc; e.insn = insn; e.rd_data = rd; e.rd_we = we; e.mis = mis;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_pc = 30'h5; in_insn = enc_i(12'd5, 3'b000, 5'd3, OPC_IMM);
    repeat (3) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || dmem_req !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl got valid=%b req=%b ready=%b want 0 0 0",
                 out_valid, dmem_req, in_ready);
      end
    end
    checks++;
    if ({out_pc, out_insn, out_rd_data, out_rd_we, out_misalign, dmem_addr,
         dmem_be, dmem_wdata, dmem_we} !== '0) begin
      errors++;
      $display("FAIL reset_data got pc=%h insn=%h rd=%h addr=%h be=%b wd=%h we=%b want all 0",
               out_pc, out_insn, out_rd_data, dmem_addr, dmem_be, dmem_wdata, dmem_we);
    end
    rst = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready got %b want 1", in_ready);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_lb();
    exp_t e;
    logic [31:0] insn;
    insn = enc_i(12'd3, 3'b000, 5'd7, OPC_LOAD);
    in_valid = 1'b1; in_pc = 30'h10; in_insn = insn; in_rs1 = 32'h1000; in_rs2 = 32'h0;
    exp_q.push_back(mk_exp(30'h10, insn, 32'hFFFF_FF80, 1'b1, 1'b0));
    tick();                                   // T+1
    in_valid = 1'b0;
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 30'h400 || dmem_be !== 4'b1000 || dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL lb_req got req=%b addr=%h be=%b we=%b want 1 400 1000 0",
               dmem_req, dmem_addr, dmem_be, dmem_we);
    end
    dmem_gnt = 1'b1;
    tick();                                   // T+2
    dmem_gnt = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lb_wait got req=%b valid=%b want 0 0", dmem_req, out_valid);
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
    tick();                                   // T+3
    dmem_rvalid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL lb_latency out_valid got %b want 1 at T+3", out_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL lb_out got %h want %h", observed(), e);
      end
    end
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_sh();
    exp_t e;
    logic [31:0] insn;
    insn = enc_s(12'd0, 3'b001);
    in_valid = 1'b1; in_pc = 30'h20; in_insn = insn; in_rs1 = 32'h2002; in_rs2 = 32'h1234_ABCD;
    exp_q.push_back(mk_exp(30'h20, insn, 32'h0, 1'b0, 1'b0));
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (dmem_req !== 1'b1 || dmem_addr !== 30'h800 || dmem_be !== 4'b1100 ||
          dmem_wdata !== 32'hABCD_ABCD || dmem_we !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL sh_req c%0d got req=%b addr=%h be=%b wd=%h we=%b rdy=%b want 1 800 1100 abcdabcd 1 0",
                 c, dmem_req, dmem_addr, dmem_be, dmem_wdata, dmem_we, in_ready);
      end
      if (c == 2) dmem_gnt = 1'b1;
      tick();
    end
    dmem_gnt = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || out_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL sh_done got req=%b valid=%b want 0 1", dmem_req, out_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL sh_out got %h want %h", observed(), e);
      end
    end
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_misalign();
    exp_t e;
    logic [31:0] insn;
    insn = enc_i(12'd0, 3'b010, 5'd9, OPC_LOAD);
    in_valid = 1'b1; in_pc = 30'h30; in_insn = insn; in_rs1 = 32'h1002;
    exp_q.push_back(mk_exp(30'h30, insn, 32'h0, 1'b0, 1'b1));
    tick();
    in_valid = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || out_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL misalign_ctrl got req=%b valid=%b want 0 1", dmem_req, out_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL misalign_out got %h want %h", observed(), e);
      end
    end
    tick();
    checks++;
    if (dmem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_after got req=%b valid=%b want 0 0", dmem_req, out_valid);
    end
  endtask

  // --------------------------------------------------------------------------
  // Four pass-through bundles (ADDI, undefined load/store funct3) streamed
  // with an out_ready stall pattern given per cycle.
  task automatic test_back_to_back(input logic [15:0] stall, input logic [AW-3:0] base);
    logic [31:0] items [4];
    exp_t e, held;
    logic hold;
    int sent, recv, last_cyc;
    items[0] = enc_i(12'd1, 3'b000, 5'd1, OPC_IMM);
    items[1] = enc_i(12'd4, 3'b011, 5'd2, OPC_LOAD);
    items[2] = enc_s(12'd8, 3'b100);
    items[3] = enc_i(12'd7, 3'b000, 5'd3, OPC_IMM);
    sent = 0; recv = 0; hold = 1'b0; last_cyc = -1; held = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = !stall[cyc];
      in_valid  = (sent < 4);
      if (sent < 4) begin
        in_pc = base + AW'(sent); in_insn = items[sent]; in_rs1 = 32'h100;
      end
      #1;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || observed() !== held) begin
          errors++;
          $display("FAIL b2b_hold cyc%0d got v=%b %h want 1 %h", cyc, out_valid, observed(), held);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready cyc%0d in_ready got %b want 0", cyc, in_ready);
        end
      end
      checks++;
      if (dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL b2b_noreq cyc%0d dmem_req got %b want 0", cyc, dmem_req);
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra cyc%0d got unexpected %h want none", cyc, observed());
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) begin
            errors++;
            $display("FAIL b2b_out cyc%0d got %h want %h", cyc, observed(), e);
          end
        end
        recv++; last_cyc = cyc;
      end
      hold = out_valid && !out_ready;
      held = observed();
      if (in_valid && in_ready) begin
        exp_q.push_back(mk_exp(in_pc, in_insn, 32'h0, 1'b0, 1'b0));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (recv != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got recv=%0d pending=%0d want 4 0", recv, exp_q.size());
    end
    if (stall == 16'h0) begin
      checks++;
      if (last_cyc != 4) begin
        errors++;
        $display("FAIL b2b_rate last output cycle got %0d want 4", last_cyc);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0]   insn;
    logic [31:0]   rs1;
    logic [31:0]   rdata;
    logic [AW-3:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          we;
    logic [31:0]   rd;
    logic          rdwe;
  } ent_t;

  task automatic test_mem_table();
    ent_t tab [8];
    exp_t e;
    tab[0] = '{enc_i(12'd2,   3'b001, 5'd8,  OPC_LOAD), 32'h4000, 32'h8765_C3A1, 30'h1000, 4'b1100, 32'h0, 1'b0, 32'hFFFF_8765, 1'b1};
    tab[1] = '{enc_i(12'd0,   3'b101, 5'd9,  OPC_LOAD), 32'h4000, 32'h8765_C3A1, 30'h1000, 4'b0011, 32'h0, 1'b0, 32'h0000_C3A1, 1'b1};
    tab[2] = '{enc_i(12'd1,   3'b000, 5'd10, OPC_LOAD), 32'h4000, 32'h8765_C3A1, 30'h1000, 4'b0010, 32'h0, 1'b0, 32'hFFFF_FFC3, 1'b1};
    tab[3] = '{enc_i(12'd2,   3'b100, 5'd11, OPC_LOAD), 32'h4000, 32'h8765_C3A1, 30'h1000, 4'b0100, 32'h0, 1'b0, 32'h0000_0065, 1'b1};
    tab[4] = '{enc_i(12'hFFC, 3'b010, 5'd0,  OPC_LOAD), 32'h4000, 32'h8765_C3A1, 30'h0FFF, 4'b1111, 32'h0, 1'b0, 32'h8765_C3A1, 1'b0};
    tab[5] = '{enc_s(12'd7,   3'b000), 32'h5000, 32'h0, 30'h1401, 4'b1000, 32'hDDDD_DDDD, 1'b1, 32'h0, 1'b0};
    tab[6] = '{enc_s(12'd8,   3'b010), 32'h5000, 32'h0, 30'h1402, 4'b1111, 32'hAABB_CCDD, 1'b1, 32'h0, 1'b0};
    tab[7] = '{enc_s(12'd0,   3'b001), 32'h5000, 32'h0, 30'h1400, 4'b0011, 32'hCCDD_CCDD, 1'b1, 32'h0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_pc = 30'h40 + AW'(i); in_insn = tab[i].insn;
      in_rs1 = tab[i].rs1; in_rs2 = 32'hAABB_CCDD;
      exp_q.push_back(mk_exp(in_pc, tab[i].insn, tab[i].rd, tab[i].rdwe, 1'b0));
      tick();
      in_valid = 1'b0;
      checks++;
      if (dmem_req !== 1'b1 || dmem_addr !== tab[i].addr || dmem_be !== tab[i].be ||
          dmem_we !== tab[i].we || (tab[i].we && dmem_wdata !== tab[i].wdata)) begin
        errors++;
        $display("FAIL tab%0d_req got req=%b addr=%h be=%b we=%b wd=%h want 1 %h %b %b %h", i,
                 dmem_req, dmem_addr, dmem_be, dmem_we, dmem_wdata,
                 tab[i].addr, tab[i].be, tab[i].we, tab[i].wdata);
      end
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      if (!tab[i].we) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL tab%0d_early out_valid got %b want 0", i, out_valid);
        end
        dmem_rvalid = 1'b1; dmem_rdata = tab[i].rdata;
        tick();
        dmem_rvalid = 1'b0;
      end
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL tab%0d_latency out_valid got %b want 1", i, out_valid);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin
          errors++;
          $display("FAIL tab%0d_out got %h want %h", i, observed(), e);
        end
      end
      tick();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_in_wait();
    exp_t e;
    logic [31:0] insn;
    in_valid = 1'b1; in_pc = 30'h60; in_insn = enc_i(12'd0, 3'b010, 5'd4, OPC_LOAD);
    in_rs1 = 32'h3000;
    tick();
    in_valid = 1'b0; dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL rstwait_idle c%0d got valid=%b req=%b want 0 0", c, out_valid, dmem_req);
      end
      tick();
    end
    insn = enc_i(12'd0, 3'b100, 5'd6, OPC_LOAD);
    in_valid = 1'b1; in_pc = 30'h61; in_insn = insn; in_rs1 = 32'h3000;
    exp_q.push_back(mk_exp(30'h61, insn, 32'h0000_00F0, 1'b1, 1'b0));
    tick();
    in_valid = 1'b0;
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 30'hC00 || dmem_be !== 4'b0001) begin
      errors++;
      $display("FAIL rstwait_req got req=%b addr=%h be=%b want 1 c00 0001", dmem_req, dmem_addr, dmem_be);
    end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_00F0;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL rstwait_latency out_valid got %b want 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL rstwait_out got %h want %h", observed(), e);
      end
    end
    tick();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_insn = 32'h0; in_rs1 = 32'h0; in_rs2 = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0; out_ready = 1'b1;
    test_reset();
    test_lb();
    test_sh();
    test_misalign();
    test_back_to_back(16'h0000, 30'h100);
    test_back_to_back(16'h0006, 30'h200);
    test_mem_table();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
